// File: rtl/sram_dp_port_arbiter.sv
// rtl/sram_dp_port_arbiter.sv - four-requester round-robin arbiter for a dual-port bit-enable SRAM
module sram_dp_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              req_valid,
    output logic [3:0]              req_ready,
    input  logic [3:0]              req_we,
    input  logic [4*ADDR_WIDTH-1:0] req_addr,
    input  logic [4*DATA_WIDTH-1:0] req_wdata,
    input  logic [4*DATA_WIDTH-1:0] req_wmask,
    output logic                    rd_valid_a,
    output logic                    rd_id_a,
    output logic [DATA_WIDTH-1:0]   rd_data_a,
    output logic                    rd_valid_b,
    output logic                    rd_id_b,
    output logic [DATA_WIDTH-1:0]   rd_data_b,
    output logic [ADDR_WIDTH-1:0]   sram_addr_a,
    output logic [ADDR_WIDTH-1:0]   sram_addr_b,
    output logic [DATA_WIDTH-1:0]   sram_din_a,
    output logic [DATA_WIDTH-1:0]   sram_din_b,
    output logic                    sram_ce_a,
    output logic                    sram_ce_b,
    output logic                    sram_wr_en_a,
    output logic                    sram_wr_en_b,
    output logic [DATA_WIDTH-1:0]   sram_bit_en_a,
    output logic [DATA_WIDTH-1:0]   sram_bit_en_b,
    input  logic [DATA_WIDTH-1:0]   sram_dout_a,
    input  logic [DATA_WIDTH-1:0]   sram_dout_b,
    output logic [CNT_WIDTH-1:0]    conflict_cnt
);

    logic [ADDR_WIDTH-1:0] addr_arr  [4];
    logic [DATA_WIDTH-1:0] wdata_arr [4];
    logic [DATA_WIDTH-1:0] wmask_arr [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign wmask_arr[i] = req_wmask[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // prio_* is the local index (0 = even, 1 = odd) that wins when both requesters are valid
    logic       prio_a, prio_b;
    logic       any_a, any_b, win_a, win_b;
    logic [1:0] sel_a, sel_b;
    logic       we_a, we_b, collision, gnt_a, gnt_b;
    logic       rd_pend_a, rd_pend_b, rd_pend_id_a, rd_pend_id_b;

    assign any_a = |req_valid[1:0];
    assign any_b = |req_valid[3:2];
    assign win_a = (&req_valid[1:0]) ? prio_a : req_valid[1];
    assign win_b = (&req_valid[3:2]) ? prio_b : req_valid[3];
    assign sel_a = {1'b0, win_a};
    assign sel_b = {1'b1, win_b};
    assign we_a  = req_we[sel_a];
    assign we_b  = req_we[sel_b];

    // Port A always wins a same-address write-write clash; port B simply retries
    assign collision = any_a & we_a & any_b & we_b & (addr_arr[sel_a] == addr_arr[sel_b]);
    assign gnt_a     = rst_n & any_a;
    assign gnt_b     = rst_n & any_b & ~collision;

    assign req_ready = {gnt_b & win_b, gnt_b & ~win_b, gnt_a & win_a, gnt_a & ~win_a};

    assign rd_data_a = sram_dout_a;
    assign rd_data_b = sram_dout_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_a        <= 1'b0;
            prio_b        <= 1'b0;
            sram_ce_a     <= 1'b1;
            sram_ce_b     <= 1'b1;
            sram_wr_en_a  <= 1'b1;
            sram_wr_en_b  <= 1'b1;
            sram_bit_en_a <= '1;
            sram_bit_en_b <= '1;
            sram_addr_a   <= '0;
            sram_addr_b   <= '0;
            sram_din_a    <= '0;
            sram_din_b    <= '0;
            rd_pend_a     <= 1'b0;
            rd_pend_b     <= 1'b0;
            rd_pend_id_a  <= 1'b0;
            rd_pend_id_b  <= 1'b0;
            rd_valid_a    <= 1'b0;
            rd_valid_b    <= 1'b0;
            rd_id_a       <= 1'b0;
            rd_id_b       <= 1'b0;
            conflict_cnt  <= '0;
        end else begin
            if (gnt_a) begin
                prio_a        <= ~win_a;
                sram_ce_a     <= 1'b0;
                sram_wr_en_a  <= ~we_a;
                sram_addr_a   <= addr_arr[sel_a];
                sram_bit_en_a <= we_a ? ~wmask_arr[sel_a] : '1;
                sram_din_a    <= we_a ? wdata_arr[sel_a] : '0;
            end else begin
                sram_ce_a     <= 1'b1;
                sram_wr_en_a  <= 1'b1;
                sram_bit_en_a <= '1;
            end

            if (gnt_b) begin
                prio_b        <= ~win_b;
                sram_ce_b     <= 1'b0;
                sram_wr_en_b  <= ~we_b;
                sram_addr_b   <= addr_arr[sel_b];
                sram_bit_en_b <= we_b ? ~wmask_arr[sel_b] : '1;
                sram_din_b    <= we_b ? wdata_arr[sel_b] : '0;
            end else begin
                sram_ce_b     <= 1'b1;
                sram_wr_en_b  <= 1'b1;
                sram_bit_en_b <= '1;
            end

            // Two-stage tag pipe lines up with the SRAM's registered read data
            rd_pend_a    <= gnt_a & ~we_a;
            rd_pend_id_a <= win_a;
            rd_valid_a   <= rd_pend_a;
            rd_id_a      <= rd_pend_id_a;
            rd_pend_b    <= gnt_b & ~we_b;
            rd_pend_id_b <= win_b;
            rd_valid_b   <= rd_pend_b;
            rd_id_b      <= rd_pend_id_b;

            if (collision && !(&conflict_cnt)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_dp_port_arbiter.sv
// tb/tb_sram_dp_port_arbiter.sv - self-checking bench for sram_dp_port_arbiter
module tb_sram_dp_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req_valid, req_ready, req_we;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata, req_wmask;
    logic            rd_valid_a, rd_id_a, rd_valid_b, rd_id_b;
    logic [DW-1:0]   rd_data_a, rd_data_b;
    logic [AW-1:0]   sram_addr_a, sram_addr_b;
    logic [DW-1:0]   sram_din_a, sram_din_b, sram_bit_en_a, sram_bit_en_b;
    logic            sram_ce_a, sram_ce_b, sram_wr_en_a, sram_wr_en_b;
    logic [DW-1:0]   sram_dout_a, sram_dout_b;
    logic [CW-1:0]   conflict_cnt;

    sram_dp_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rd_valid_a(rd_valid_a), .rd_id_a(rd_id_a), .rd_data_a(rd_data_a),
        .rd_valid_b(rd_valid_b), .rd_id_b(rd_id_b), .rd_data_b(rd_data_b),
        .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b),
        .sram_din_a(sram_din_a), .sram_din_b(sram_din_b),
        .sram_ce_a(sram_ce_a), .sram_ce_b(sram_ce_b),
        .sram_wr_en_a(sram_wr_en_a), .sram_wr_en_b(sram_wr_en_b),
        .sram_bit_en_a(sram_bit_en_a), .sram_bit_en_b(sram_bit_en_b),
        .sram_dout_a(sram_dout_a), .sram_dout_b(sram_dout_b),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port macro: registered reads see the memory before same-edge writes
    logic [DW-1:0] sram_mem [1024] = '{default: '0};
    always @(posedge clk) begin
        if (!sram_ce_a && sram_wr_en_a) sram_dout_a <= sram_mem[sram_addr_a];
        if (!sram_ce_b && sram_wr_en_b) sram_dout_b <= sram_mem[sram_addr_b];
        if (!sram_ce_a && !sram_wr_en_a)
            sram_mem[sram_addr_a] <= (sram_mem[sram_addr_a] & sram_bit_en_a) | (sram_din_a & ~sram_bit_en_a);
        if (!sram_ce_b && !sram_wr_en_b)
            sram_mem[sram_addr_b] <= (sram_mem[sram_addr_b] & sram_bit_en_b) | (sram_din_b & ~sram_bit_en_b);
    end

    logic          obs_ce [2], obs_wr [2], obs_rdv [2], obs_rdid [2];
    logic [DW-1:0] obs_be [2], obs_din [2], obs_rdd [2];
    logic [AW-1:0] obs_addr [2];
    assign obs_ce   = '{sram_ce_a, sram_ce_b};
    assign obs_wr   = '{sram_wr_en_a, sram_wr_en_b};
    assign obs_rdv  = '{rd_valid_a, rd_valid_b};
    assign obs_rdid = '{rd_id_a, rd_id_b};
    assign obs_be   = '{sram_bit_en_a, sram_bit_en_b};
    assign obs_din  = '{sram_din_a, sram_din_b};
    assign obs_rdd  = '{rd_data_a, rd_data_b};
    assign obs_addr = '{sram_addr_a, sram_addr_b};

    int checks = 0;
    int errors = 0;

    logic [3:0]    m_valid, m_we;
    logic [AW-1:0] m_addr  [4];
    logic [DW-1:0] m_wdata [4];
    logic [DW-1:0] m_wmask [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW]  = m_addr[i];
            req_wdata[i*DW +: DW] = m_wdata[i];
            req_wmask[i*DW +: DW] = m_wmask[i];
        end
        req_valid = m_valid;
        req_we    = m_we;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        m_valid = '0;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Round-robin rule: with both valid, the one not granted last on that port wins
    function automatic int winner(logic [3:0] v, int base, int last);
        if (v[base] && v[base+1]) return (last == base) ? base + 1 : base;
        if (v[base]) return base;
        if (v[base+1]) return base + 1;
        return -1;
    endfunction

    typedef struct {
        logic [3:0]    valid;
        logic [3:0]    we;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [3:0]    ready;
        int            cnt;
    } vec_t;
    vec_t tbl [14];

    int            last [2];
    int            w [2];
    int            mcnt;
    logic [3:0]    exp_r;
    logic          e_ce [2], e_wr [2];
    logic [DW-1:0] e_be [2], e_din [2];
    logic [AW-1:0] e_addr [2];
    logic          slot_v [2][4];
    int            slot_id [2][4];
    logic [DW-1:0] slot_d [2][4];
    logic [DW-1:0] mdl_mem [1024] = '{default: '0};

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 10'h000, 10'h000, 4'b0101, 0};
        tbl[1]  = '{4'b1111, 4'b0000, 10'h000, 10'h000, 4'b1010, 0};
        tbl[2]  = '{4'b0101, 4'b0101, 10'h3FF, 10'h3FF, 4'b0001, 1};
        tbl[3]  = '{4'b0101, 4'b0101, 10'h3FF, 10'h3FF, 4'b0001, 2};
        tbl[4]  = '{4'b0100, 4'b0100, 10'h3FF, 10'h3FF, 4'b0100, 2};
        tbl[5]  = '{4'b0101, 4'b0101, 10'h3FF, 10'h3FE, 4'b0101, 2};
        tbl[6]  = '{4'b1100, 4'b0000, 10'h000, 10'h001, 4'b1000, 2};
        tbl[7]  = '{4'b0011, 4'b0011, 10'h010, 10'h000, 4'b0010, 2};
        tbl[8]  = '{4'b1111, 4'b1111, 10'h007, 10'h007, 4'b0001, 3};
        tbl[9]  = '{4'b1111, 4'b1111, 10'h007, 10'h007, 4'b0010, 4};
        tbl[10] = '{4'b1111, 4'b1010, 10'h007, 10'h007, 4'b0101, 4};
        tbl[11] = '{4'b1111, 4'b0101, 10'h007, 10'h007, 4'b1010, 4};
        tbl[12] = '{4'b1111, 4'b1001, 10'h007, 10'h007, 4'b0101, 4};
        tbl[13] = '{4'b0000, 4'b0000, 10'h007, 10'h007, 4'b0000, 4};

        m_valid = '0;
        m_we    = '0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_wmask[i] = '0;
        end

        // Reset and idle
        rst_n   = 1'b0;
        m_valid = 4'hF;
        drive();
        #1;
        chk("ready_in_reset", req_ready, 4'h0);
        tick();
        tick();
        rst_n   = 1'b1;
        m_valid = '0;
        drive();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("idle_ce_a", sram_ce_a, 1'b1);
            chk("idle_ce_b", sram_ce_b, 1'b1);
            chk("idle_wr_a", sram_wr_en_a, 1'b1);
            chk("idle_wr_b", sram_wr_en_b, 1'b1);
            chk("idle_be_a", sram_bit_en_a, 8'hFF);
            chk("idle_be_b", sram_bit_en_b, 8'hFF);
            chk("idle_rdv", {rd_valid_a, rd_valid_b}, 2'b00);
            chk("idle_cnt", conflict_cnt, 0);
            tick();
        end

        // Randomized traffic against the reference model
        reset_dut();
        last[0] = 1;
        last[1] = 3;
        mcnt    = 0;
        for (int p = 0; p < 2; p++) begin
            e_addr[p] = '0;
            e_din[p]  = '0;
            for (int s = 0; s < 4; s++) slot_v[p][s] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            m_valid = 4'($urandom);
            m_we    = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                m_addr[i]  = AW'($urandom_range(0, 7));
                m_wdata[i] = DW'($urandom);
                m_wmask[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
            end
            drive();
            #1;
            w[0] = winner(m_valid, 0, last[0]);
            w[1] = winner(m_valid, 2, last[1]);
            if (w[0] >= 0 && w[1] >= 0 && m_we[w[0]] && m_we[w[1]] && m_addr[w[0]] == m_addr[w[1]]) begin
                w[1] = -1;
                if (mcnt < CMAX) mcnt++;
            end
            exp_r = '0;
            for (int p = 0; p < 2; p++) if (w[p] >= 0) exp_r[w[p]] = 1'b1;
            chk("rnd_ready", req_ready, exp_r);
            for (int p = 0; p < 2; p++) begin
                if (w[p] >= 0) begin
                    last[p]   = w[p];
                    e_ce[p]   = 1'b0;
                    e_wr[p]   = !m_we[w[p]];
                    e_be[p]   = m_we[w[p]] ? ~m_wmask[w[p]] : 8'hFF;
                    e_addr[p] = m_addr[w[p]];
                    e_din[p]  = m_we[w[p]] ? m_wdata[w[p]] : 8'h00;
                    if (!m_we[w[p]]) begin
                        slot_v[p][(c+2)%4]  = 1'b1;
                        slot_id[p][(c+2)%4] = w[p] - 2*p;
                        slot_d[p][(c+2)%4]  = mdl_mem[m_addr[w[p]]];
                    end
                end else begin
                    e_ce[p] = 1'b1;
                    e_wr[p] = 1'b1;
                    e_be[p] = 8'hFF;
                end
            end
            for (int p = 0; p < 2; p++)
                if (w[p] >= 0 && m_we[w[p]])
                    mdl_mem[m_addr[w[p]]] = (mdl_mem[m_addr[w[p]]] & ~m_wmask[w[p]]) | (m_wdata[w[p]] & m_wmask[w[p]]);
            tick();
            for (int p = 0; p < 2; p++) begin
                chk("rnd_ce", obs_ce[p], e_ce[p]);
                chk("rnd_wr_en", obs_wr[p], e_wr[p]);
                chk("rnd_bit_en", obs_be[p], e_be[p]);
                chk("rnd_addr", obs_addr[p], e_addr[p]);
                chk("rnd_din", obs_din[p], e_din[p]);
                chk("rnd_rd_valid", obs_rdv[p], slot_v[p][(c+1)%4]);
                if (slot_v[p][(c+1)%4]) begin
                    chk("rnd_rd_id", obs_rdid[p], slot_id[p][(c+1)%4]);
                    chk("rnd_rd_data", obs_rdd[p], slot_d[p][(c+1)%4]);
                end
                slot_v[p][(c+1)%4] = 1'b0;
            end
            chk("rnd_cnt", conflict_cnt, mcnt);
        end

        // Table-driven arbitration and collision vectors
        reset_dut();
        for (int r = 0; r < 14; r++) begin
            m_valid = tbl[r].valid;
            m_we    = tbl[r].we;
            for (int i = 0; i < 4; i++) begin
                m_addr[i]  = (i < 2) ? tbl[r].addr_a : tbl[r].addr_b;
                m_wdata[i] = 8'h3C;
                m_wmask[i] = 8'hFF;
            end
            drive();
            #1;
            chk("tbl_ready", req_ready, tbl[r].ready);
            tick();
            chk("tbl_cnt", conflict_cnt, tbl[r].cnt);
        end

        // Write 0xA5 to 0x05 from requester 0, then read it back
        m_valid = 4'b0001; m_we = 4'b0001;
        m_addr[0] = 10'h005; m_wdata[0] = 8'hA5; m_wmask[0] = 8'hFF;
        drive();
        #1;
        chk("wr_ready", req_ready, 4'b0001);
        tick();
        chk("wr_ce_a", sram_ce_a, 1'b0);
        chk("wr_wr_en_a", sram_wr_en_a, 1'b0);
        chk("wr_bit_en_a", sram_bit_en_a, 8'h00);
        chk("wr_addr_a", sram_addr_a, 10'h005);
        chk("wr_din_a", sram_din_a, 8'hA5);
        m_we = 4'b0000;
        drive();
        #1;
        chk("rd_ready", req_ready, 4'b0001);
        tick();
        chk("rd_ce_a", sram_ce_a, 1'b0);
        chk("rd_wr_en_a", sram_wr_en_a, 1'b1);
        chk("rd_din_a", sram_din_a, 8'h00);
        chk("rd_early_valid", rd_valid_a, 1'b0);
        m_valid = '0;
        drive();
        tick();
        chk("rd_valid_a", rd_valid_a, 1'b1);
        chk("rd_id_a", rd_id_a, 1'b0);
        chk("rd_data_a", rd_data_a, 8'hA5);
        tick();
        chk("rd_valid_once", rd_valid_a, 1'b0);

        // Masked write from requester 1 (low nibble cleared), read by requester 0
        m_valid = 4'b0010; m_we = 4'b0010;
        m_addr[1] = 10'h005; m_wdata[1] = 8'h00; m_wmask[1] = 8'h0F;
        drive();
        #1;
        chk("mwr_ready", req_ready, 4'b0010);
        tick();
        chk("mwr_bit_en_a", sram_bit_en_a, 8'hF0);
        m_valid = 4'b0001; m_we = 4'b0000;
        drive();
        #1;
        chk("mrd_ready", req_ready, 4'b0001);
        tick();
        m_valid = '0;
        drive();
        tick();
        chk("mrd_valid_a", rd_valid_a, 1'b1);
        chk("mrd_data_a", rd_data_a, 8'hA0);

        // Requesters 0/1 read back-to-back for six cycles
        reset_dut();
        m_addr[0] = 10'h005; m_addr[1] = 10'h005; m_we = '0;
        for (int i = 0; i < 8; i++) begin
            m_valid = (i < 6) ? 4'b0011 : 4'b0000;
            drive();
            #1;
            if (i < 6) chk("alt_ready", req_ready, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            chk("alt_rd_valid", rd_valid_a, i >= 2);
            if (i >= 2) begin
                chk("alt_rd_id", rd_id_a, (i - 2) % 2);
                chk("alt_rd_data", rd_data_a, 8'hA0);
            end
            tick();
        end

        // Read on port B in flight when reset hits
        m_valid = 4'b0100; m_we = '0; m_addr[2] = 10'h005;
        drive();
        #1;
        chk("fl_ready", req_ready, 4'b0100);
        tick();
        rst_n   = 1'b0;
        m_valid = 4'b1111;
        drive();
        #1;
        chk("fl_ready_rst", req_ready, 4'b0000);
        tick();
        rst_n   = 1'b1;
        m_valid = 4'b1100;
        m_addr[3] = 10'h005;
        drive();
        #1;
        chk("fl_rd_valid_b", rd_valid_b, 1'b0);
        chk("fl_ce_b", sram_ce_b, 1'b1);
        chk("fl_addr_b", sram_addr_b, 10'h000);
        chk("fl_cnt", conflict_cnt, 0);
        chk("fl_ready_even", req_ready, 4'b0100);
        m_valid = '0;
        tick();
        drive();
        chk("fl_drop_stays", rd_valid_b, 1'b0);
        tick();
        chk("fl_new_valid_b", rd_valid_b, 1'b1);
        chk("fl_new_id_b", rd_id_b, 1'b0);
        chk("fl_new_data_b", rd_data_b, 8'hA0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
